// File: rtl/ceres_param_pkg.sv
// Shared watchdog register map, key values and feeder state encoding.
package ceres_param;

  localparam logic [3:0] WDT_REG_CTRL   = 4'h0;
  localparam logic [3:0] WDT_REG_LOAD   = 4'h1;
  localparam logic [3:0] WDT_REG_COUNT  = 4'h2;
  localparam logic [3:0] WDT_REG_WINDOW = 4'h3;
  localparam logic [3:0] WDT_REG_KEY    = 4'h4;
  localparam logic [3:0] WDT_REG_STATUS = 4'h5;

  localparam logic [31:0] WDT_KEY_REFRESH = 32'h5A5A_5A5A;
  localparam logic [31:0] WDT_KEY_UNLOCK  = 32'h1234_5678;
  localparam logic [31:0] WDT_KEY_LOCK    = 32'hDEAD_BEEF;

  typedef enum logic [3:0] {
    FS_IDLE,
    FS_UNLOCK,
    FS_LOAD,
    FS_WINDOW,
    FS_CTRL,
    FS_LOCK,
    FS_WAIT,
    FS_FEED,
    FS_RDST
  } wdt_feeder_state_e;

endpackage

// File: rtl/wdt_feeder.sv
// Autonomous watchdog feeder: programs and locks the watchdog, then refreshes
// it periodically only while the monitored agent keeps reporting alive.
module wdt_feeder
  import ceres_param::*;
#(
  parameter logic [31:0] FEED_PERIOD = 32'd1000,
  parameter logic [31:0] LOAD_VAL    = 32'd1500,
  parameter logic [31:0] WINDOW_VAL  = 32'd1000,
  parameter logic [31:0] CTRL_VAL    = 32'h0000_0317
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        alive_i,
  input  logic        gnt_i,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  adr_o,
  output logic [3:0]  byte_sel_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        cfg_done_o,
  output logic        starve_o,
  output logic [3:0]  status_o,
  output logic [15:0] feed_cnt_o
);

  wdt_feeder_state_e state_q, state_d;
  logic [31:0]       period_q;
  logic              alive_q;
  logic              granted;
  logic              bus_stb, bus_we;
  logic [3:0]        bus_adr;
  logic [31:0]       bus_dat;
  logic              unused_dat;

  assign granted    = stb_o & gnt_i;
  assign unused_dat = ^dat_i[31:4];

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= FS_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode plus bus fields of the state being entered; the bus
  // fields are registered so they line up with state_q on the next cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_IDLE:   if (start_i) state_d = FS_UNLOCK;
      FS_UNLOCK: if (granted) state_d = FS_LOAD;
      FS_LOAD:   if (granted) state_d = FS_WINDOW;
      FS_WINDOW: if (granted) state_d = FS_CTRL;
      FS_CTRL:   if (granted) state_d = FS_LOCK;
      FS_LOCK:   if (granted) state_d = FS_WAIT;
      FS_WAIT:   if (period_q == '0) state_d = alive_q ? FS_FEED : FS_RDST;
      FS_FEED:   if (granted) state_d = FS_RDST;
      FS_RDST:   if (granted) state_d = FS_WAIT;
      default:   state_d = FS_IDLE;
    endcase

    bus_stb = 1'b0;
    bus_we  = 1'b0;
    bus_adr = '0;
    bus_dat = '0;
    unique case (state_d)
      FS_UNLOCK: begin bus_stb = 1'b1; bus_we = 1'b1; bus_adr = WDT_REG_KEY;    bus_dat = WDT_KEY_UNLOCK;  end
      FS_LOAD:   begin bus_stb = 1'b1; bus_we = 1'b1; bus_adr = WDT_REG_LOAD;   bus_dat = LOAD_VAL;        end
      FS_WINDOW: begin bus_stb = 1'b1; bus_we = 1'b1; bus_adr = WDT_REG_WINDOW; bus_dat = WINDOW_VAL;      end
      FS_CTRL:   begin bus_stb = 1'b1; bus_we = 1'b1; bus_adr = WDT_REG_CTRL;   bus_dat = CTRL_VAL;        end
      FS_LOCK:   begin bus_stb = 1'b1; bus_we = 1'b1; bus_adr = WDT_REG_KEY;    bus_dat = WDT_KEY_LOCK;    end
      FS_FEED:   begin bus_stb = 1'b1; bus_we = 1'b1; bus_adr = WDT_REG_KEY;    bus_dat = WDT_KEY_REFRESH; end
      FS_RDST:   begin bus_stb = 1'b1; bus_adr = WDT_REG_STATUS; end
      default:   ;
    endcase
  end

  // Registered bus outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      adr_o      <= '0;
      dat_o      <= '0;
      byte_sel_o <= '0;
    end else begin
      stb_o      <= bus_stb;
      we_o       <= bus_we;
      adr_o      <= bus_adr;
      dat_o      <= bus_dat;
      byte_sel_o <= bus_stb ? 4'hF : 4'h0;
    end
  end

  // Period counter: reloaded on every entry into WAIT, counts down inside it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      period_q <= '0;
    end else if (state_d == FS_WAIT && state_q != FS_WAIT) begin
      period_q <= FEED_PERIOD - 32'd1;
    end else if (state_q == FS_WAIT && period_q != '0) begin
      period_q <= period_q - 32'd1;
    end
  end

  // Alive flag; a heartbeat coinciding with the refresh grant wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                             alive_q <= 1'b0;
    else if (alive_i)                        alive_q <= 1'b1;
    else if (state_q == FS_FEED && granted)  alive_q <= 1'b0;
  end

  // Status flags, captured STATUS nibble and granted-kick counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_done_o <= 1'b0;
      starve_o   <= 1'b0;
      status_o   <= '0;
      feed_cnt_o <= '0;
    end else begin
      if (state_q == FS_LOCK && granted) cfg_done_o <= 1'b1;
      if (state_q == FS_WAIT && period_q == '0 && !alive_q) starve_o <= 1'b1;
      if (state_q == FS_FEED && granted) begin
        starve_o   <= 1'b0;
        feed_cnt_o <= feed_cnt_o + 16'd1;
      end
      if (state_q == FS_RDST && granted) status_o <= dat_i[3:0];
    end
  end

endmodule

// File: tb/tb_wdt_feeder.sv
// Bench for wdt_feeder: scoreboard of expected bus accesses, a small watchdog
// model answering STATUS reads, and directed configuration/feed/reset scenarios.
module tb_wdt_feeder;

  localparam logic [31:0] P_PERIOD = 32'd20;
  localparam logic [31:0] P_LOAD   = 32'd40;
  localparam logic [31:0] P_WINDOW = 32'd30;
  localparam logic [31:0] P_CTRL   = 32'h0000_0317;

  logic        clk = 1'b0;
  logic        rst_n, start, alive, gnt;
  logic        stb_o, we_o;
  logic [3:0]  adr_o, byte_sel_o, status_o;
  logic [31:0] dat_o, dat_i;
  logic        cfg_done_o, starve_o;
  logic [15:0] feed_cnt_o;

  always #5 clk = ~clk;

  wdt_feeder #(
    .FEED_PERIOD (P_PERIOD),
    .LOAD_VAL    (P_LOAD),
    .WINDOW_VAL  (P_WINDOW),
    .CTRL_VAL    (P_CTRL)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .alive_i    (alive),
    .gnt_i      (gnt),
    .stb_o      (stb_o),
    .we_o       (we_o),
    .adr_o      (adr_o),
    .byte_sel_o (byte_sel_o),
    .dat_o      (dat_o),
    .dat_i      (dat_i),
    .cfg_done_o (cfg_done_o),
    .starve_o   (starve_o),
    .status_o   (status_o),
    .feed_cnt_o (feed_cnt_o)
  );

  // Watchdog model: counts down once enabled, raises a sticky reset at zero,
  // flags a window violation on a refresh that arrives above the window.
  logic [31:0] m_load = '0, m_window = '0, m_cnt = '0;
  logic        m_en = 1'b0, m_winviol = 1'b0, m_wdt_rst = 1'b0;
  logic        win_strict = 1'b0;
  logic [31:0] m_thr;

  assign m_thr = win_strict ? 32'd5 : m_window;
  assign dat_i = {28'd0, m_winviol, 2'b00, m_en};

  always @(posedge clk) begin
    if (stb_o && gnt && we_o) begin
      case (adr_o)
        4'h0: begin m_en <= dat_o[0]; m_cnt <= m_load; end
        4'h1: m_load <= dat_o;
        4'h3: m_window <= dat_o;
        4'h4: if (dat_o == 32'h5A5A_5A5A) begin
                if (m_cnt > m_thr) m_winviol <= 1'b1;
                m_cnt <= m_load;
              end
        default: ;
      endcase
    end else if (m_en) begin
      if (m_cnt == '0) m_wdt_rst <= 1'b1;
      else             m_cnt <= m_cnt - 32'd1;
    end
  end

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dat;
  } acc_t;

  typedef struct {
    int unsigned stall;
    logic [3:0]  adr;
    logic [31:0] dat;
  } cfg_vec_t;

  acc_t     sb[$];
  cfg_vec_t cfg_tab[5];
  int       n_vec = 0, n_bad = 0;
  int       cyc_n = 0, last_kick = -1;
  bit       chk_period = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [3:0] adr, input logic [31:0] dat);
    acc_t e;
    e.we = we; e.adr = adr; e.dat = dat;
    sb.push_back(e);
  endtask

  task automatic push_cfg();
    push(1'b1, 4'h4, 32'h1234_5678);
    push(1'b1, 4'h1, P_LOAD);
    push(1'b1, 4'h3, P_WINDOW);
    push(1'b1, 4'h0, P_CTRL);
    push(1'b1, 4'h4, 32'hDEAD_BEEF);
  endtask

  task automatic monitor();
    acc_t e;
    if (sb.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL unexpected_access: we=%0d adr=%h dat=%h, expected no access", we_o, adr_o, dat_o);
    end else begin
      e = sb.pop_front();
      chk("bus_we", 32'(we_o), 32'(e.we));
      chk("bus_adr", 32'(adr_o), 32'(e.adr));
      chk("byte_sel", 32'(byte_sel_o), 32'hF);
      if (e.we) chk("bus_dat", dat_o, e.dat);
      if (e.we && e.adr == 4'h4 && e.dat == 32'h5A5A_5A5A) begin
        if (chk_period && last_kick >= 0) chk("kick_interval", 32'(cyc_n - last_kick), 32'd22);
        last_kick = cyc_n;
      end
    end
  endtask

  // One clock: bus monitor at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc_n++;
    if (rst_n && stb_o && gnt) monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sb(input int unsigned budget, input bit pulse);
    for (int unsigned c = 0; c < budget && sb.size() != 0; c++) begin
      alive = pulse && (c % 10 == 5);
      step();
    end
    alive = 1'b0;
    if (sb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL sb_timeout: %0d accesses pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_all_reset();
    chk("rst_stb", 32'(stb_o), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_adr", 32'(adr_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_bsel", 32'(byte_sel_o), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done_o), 32'd0);
    chk("rst_starve", 32'(starve_o), 32'd0);
    chk("rst_status", 32'(status_o), 32'd0);
    chk("rst_feed_cnt", 32'(feed_cnt_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; alive = 1'b0; gnt = 1'b0;
    cfg_tab[0] = '{0, 4'h4, 32'h1234_5678};
    cfg_tab[1] = '{7, 4'h1, P_LOAD};
    cfg_tab[2] = '{0, 4'h3, P_WINDOW};
    cfg_tab[3] = '{0, 4'h0, P_CTRL};
    cfg_tab[4] = '{0, 4'h4, 32'hDEAD_BEEF};

    step(); step();
    chk_all_reset();
    rst_n = 1'b1;
    step();

    // Configuration with a grant stall during LOAD.
    push_cfg();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int unsigned s = 0; s < cfg_tab[i].stall; s++) begin
        chk("stall_stb", 32'(stb_o), 32'd1);
        chk("stall_adr", 32'(adr_o), 32'(cfg_tab[i].adr));
        chk("stall_dat", dat_o, cfg_tab[i].dat);
        step();
      end
      gnt = 1'b1;
      chk("cfg_stb", 32'(stb_o), 32'd1);
      chk("cfg_adr", 32'(adr_o), 32'(cfg_tab[i].adr));
      step();
      gnt = 1'b0;
    end
    chk("cfg_done", 32'(cfg_done_o), 32'd1);
    chk("wait_stb", 32'(stb_o), 32'd0);
    chk("cfg_sb_empty", 32'(sb.size()), 32'd0);
    gnt = 1'b1;

    // Healthy feeding.
    chk_period = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push(1'b1, 4'h4, 32'h5A5A_5A5A);
      push(1'b0, 4'h5, 32'd0);
      wait_sb(30, 1'b1);
      chk("feed_cnt", 32'(feed_cnt_o), 32'(k + 1));
      chk("status_ok", 32'(status_o), 32'h1);
    end
    chk_period = 1'b0;
    chk("healthy_no_wdt_rst", 32'(m_wdt_rst), 32'd0);
    chk("healthy_starve", 32'(starve_o), 32'd0);

    // Starvation: only STATUS reads, watchdog expires.
    for (int k = 0; k < 3; k++) begin
      push(1'b0, 4'h5, 32'd0);
      wait_sb(30, 1'b0);
      chk("starve_set", 32'(starve_o), 32'd1);
      chk("starve_feed_cnt", 32'(feed_cnt_o), 32'd6);
    end
    chk("starve_wdt_rst", 32'(m_wdt_rst), 32'd1);

    // Resume after a single heartbeat.
    push(1'b1, 4'h4, 32'h5A5A_5A5A);
    push(1'b0, 4'h5, 32'd0);
    wait_sb(30, 1'b1);
    chk("resume_starve", 32'(starve_o), 32'd0);
    chk("resume_feed_cnt", 32'(feed_cnt_o), 32'd7);

    // Watchdog reports a window violation on the next kick.
    win_strict = 1'b1;
    push(1'b1, 4'h4, 32'h5A5A_5A5A);
    push(1'b0, 4'h5, 32'd0);
    wait_sb(30, 1'b1);
    chk("winviol_status", 32'(status_o), 32'h9);
    chk("winviol_feed_cnt", 32'(feed_cnt_o), 32'd8);

    // Asynchronous reset in the middle of the WINDOW write.
    rst_n = 1'b0; gnt = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    push(1'b1, 4'h4, 32'h1234_5678);
    push(1'b1, 4'h1, P_LOAD);
    start = 1'b1; step(); start = 1'b0;
    gnt = 1'b1; step(); step(); gnt = 1'b0;
    chk("win_stb", 32'(stb_o), 32'd1);
    chk("win_adr", 32'(adr_o), 32'h3);
    chk("win_dat", dat_o, P_WINDOW);
    #2 rst_n = 1'b0;
    #1 chk_all_reset();
    step(); step();
    rst_n = 1'b1;
    step(); step();
    chk("no_resume_stb", 32'(stb_o), 32'd0);
    chk("no_resume_cfg_done", 32'(cfg_done_o), 32'd0);

    // Zero-wait configuration completes five cycles after start.
    gnt = 1'b1;
    push_cfg();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("fast_cfg_pending", 32'(cfg_done_o), 32'd0);
      step();
    end
    chk("fast_cfg_done", 32'(cfg_done_o), 32'd1);
    chk("fast_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wdt_feeder.md
# wdt_feeder

Autonomous bus initiator that drives the watchdog's register interface from the other side: programs LOAD, WINDOW and CTRL, locks the configuration, then issues periodic refresh kicks only while a system heartbeat is present. Sits between the core's liveness signal and the watchdog peripheral, sharing the watchdog's register bus through an arbiter. It provides hardware-guaranteed feeding with a software-liveness gate, so the watchdog fires when the monitored agent stops reporting alive.

## Interface
- FEED_PERIOD, 32'd1000: cycles from a granted kick (or granted LOCK) to the next kick decision; legal range 2..2^32-1
- LOAD_VAL, 32'd1500: value written to watchdog LOAD
- WINDOW_VAL, 32'd1000: value written to watchdog WINDOW
- CTRL_VAL, 32'h0000_0317: value written to watchdog CTRL (EN, RSTEN, WINEN, IE, EWI_DIV=3)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; begins configuration from IDLE, ignored elsewhere
- alive_i  in  1  heartbeat pulse from monitored agent
- gnt_i  in  1  arbiter grant; an access completes in the cycle stb_o & gnt_i
- stb_o  out  1  access request
- we_o  out  1  1 = write, 0 = read
- adr_o  out  4  watchdog word address
- byte_sel_o  out  4  always 4'hF while stb_o
- dat_o  out  32  write data
- dat_i  in  32  read data, valid in the granted cycle of a read
- cfg_done_o  out  1  high after LOCK granted, until reset
- starve_o  out  1  sticky; set when a kick is withheld
- status_o  out  4  last STATUS[3:0] captured
- feed_cnt_o  out  16  granted kicks, wraps at 16'hFFFF -> 0

## Operation
- FSM states: IDLE, UNLOCK, LOAD, WINDOW, CTRL, LOCK, WAIT, FEED, RDST.
- IDLE -start_i-> UNLOCK. Each access state holds stb_o and the address/data below stable until gnt_i, then advances:
  - UNLOCK: write KEY (4'h4) = 32'h1234_5678
  - LOAD: write 4'h1 = LOAD_VAL
  - WINDOW: write 4'h3 = WINDOW_VAL
  - CTRL: write 4'h0 = CTRL_VAL
  - LOCK: write KEY = 32'hDEAD_BEEF
  - FEED: write KEY = 32'h5A5A_5A5A
  - RDST: read STATUS (4'h5)
- Transition targets: LOCK → WAIT (sets cfg_done_o); FEED → RDST (feed_cnt_o+1); RDST → WAIT (status_o <= dat_i[3:0]).
- WAIT: period counter decrements; at 0, if alive flag set → FEED, else set starve_o and → RDST. Counter is reloaded to FEED_PERIOD-1 whenever WAIT is entered.
- Alive flag: set by alive_i in any state, cleared on the granted FEED cycle; an alive_i coincident with that clear leaves the flag set.
- starve_o clears only on a granted FEED. The next alive_i reaching a WAIT expiry resumes feeding.
- Outputs while not in an access state: stb_o=0, we_o=0, adr_o=0, dat_o=0, byte_sel_o=0.
- Configuration constraint (documented, not checked): LOAD_VAL-WINDOW_VAL < FEED_PERIOD+3 < LOAD_VAL. The +3 covers FEED, RDST and zero-wait grants.

## Timing
- Reset values: FSM IDLE, stb_o/we_o 0, adr_o/dat_o/byte_sel_o 0, cfg_done_o 0, starve_o 0, status_o 0, feed_cnt_o 0, alive flag 0.
- Reset is asynchronous at any point, including mid-access. stb_o drops immediately, with no partial sequence resumption.
- Outputs are registered. stb_o asserts the cycle after entering an access state.
- With gnt_i tied 1, the configuration takes 5 cycles after the start_i cycle.
- FEED_PERIOD cycles in WAIT, then FEED (1 cycle), then RDST (1 cycle).
- No bus timeout: an ungranted access stalls indefinitely.

## Structure
- Add to ceres_param, shared with the watchdog:
  - WDT_REG_CTRL/LOAD/COUNT/WINDOW/KEY/STATUS address constants
  - WDT_KEY_REFRESH/UNLOCK/LOCK constants
  - a wdt_feeder_state_e enum
- Single module, no sub-module. One FSM, one 32-bit period counter, one 16-bit feed counter.

## Test plan
- Config sequence, gnt_i=1: start_i → bench records writes in order (4,12345678) (1,LOAD_VAL) (3,WINDOW_VAL) (0,CTRL_VAL) (4,DEADBEEF); cfg_done_o=1.
- Grant stall: gnt_i low 7 cycles during LOAD → stb_o/adr_o/dat_o stable for 8 cycles; sequence still completes in order.
- Healthy feed, FEED_PERIOD=20: alive_i every 10 cycles → KEY=5A5A5A5A every 22 cycles; feed_cnt_o increments; watchdog model never resets.
- Starvation: alive_i stopped → starve_o=1, no further kicks; watchdog model reaches 0 and asserts reset.
- Resume: alive_i pulse after starvation → next kick issued, starve_o clears.
- Window status and reset corner: the watchdog model reports WINVIOL → status_o=4'b1xxx after RDST. Separately, rst_ni pulse during the WINDOW write → all outputs return to reset values and stb_o is 0 within the same cycle.
